// File: rtl/traffic_light_controller.sv
// Fixed-time Moore controller for a four-signal junction (M1, M2, main turn, side).
// Six timed phases; every lamp output is one-hot {red, yellow, green}.
module traffic_light_controller #(
  parameter int T_MAIN = 7,
  parameter int T_TURN = 5,
  parameter int T_SIDE = 3,
  parameter int T_YEL  = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] light_M1,
  output logic [2:0] light_S,
  output logic [2:0] light_MT,
  output logic [2:0] light_M2
);

  localparam int T_MAX_A = (T_MAIN > T_TURN) ? T_MAIN : T_TURN;
  localparam int T_MAX_B = (T_SIDE > T_YEL) ? T_SIDE : T_YEL;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] LAST_MAIN = CNT_W'(T_MAIN - 1);
  localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(T_TURN - 1);
  localparam logic [CNT_W-1:0] LAST_SIDE = CNT_W'(T_SIDE - 1);
  localparam logic [CNT_W-1:0] LAST_YEL  = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef enum logic [2:0] {
    S1 = 3'd0,
    S2 = 3'd1,
    S3 = 3'd2,
    S4 = 3'd3,
    S5 = 3'd4,
    S6 = 3'd5
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  state_t           succ_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  logic [CNT_W-1:0] last_cnt_s;
  logic             illegal_s;

  // Phase and cycle-counter registers; reset parks the junction in S1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S1;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
    end
  end

  // Phase duration lookup, successor phase and counter advance.
  always_comb begin
    last_cnt_s   = LAST_MAIN;
    succ_state_s = S1;
    illegal_s    = 1'b0;
    next_state_s = state_r;
    next_cnt_s   = cnt_r + CNT_ONE;
    case (state_r)
      S1: begin last_cnt_s = LAST_MAIN; succ_state_s = S2; end
      S2: begin last_cnt_s = LAST_YEL;  succ_state_s = S3; end
      S3: begin last_cnt_s = LAST_TURN; succ_state_s = S4; end
      S4: begin last_cnt_s = LAST_YEL;  succ_state_s = S5; end
      S5: begin last_cnt_s = LAST_SIDE; succ_state_s = S6; end
      S6: begin last_cnt_s = LAST_YEL;  succ_state_s = S1; end
      default: begin
        last_cnt_s   = CNT_ZERO;
        succ_state_s = S1;
        illegal_s    = 1'b1;
      end
    endcase
    // An unreachable encoding restarts the cycle cleanly rather than finishing a phase.
    if (illegal_s) begin
      next_state_s = S1;
      next_cnt_s   = CNT_ZERO;
    end else if (cnt_r == last_cnt_s) begin
      next_state_s = succ_state_s;
      next_cnt_s   = CNT_ZERO;
    end else begin
      next_state_s = state_r;
      next_cnt_s   = cnt_r + CNT_ONE;
    end
  end

  // Lamp decode from the phase alone; anything unexpected shows all-red.
  always_comb begin
    light_M1 = RED;
    light_M2 = RED;
    light_MT = RED;
    light_S  = RED;
    case (state_r)
      S1: begin light_M1 = GRN; light_M2 = GRN; light_MT = RED; light_S = RED; end
      S2: begin light_M1 = GRN; light_M2 = YEL; light_MT = RED; light_S = RED; end
      S3: begin light_M1 = GRN; light_M2 = RED; light_MT = GRN; light_S = RED; end
      S4: begin light_M1 = YEL; light_M2 = RED; light_MT = YEL; light_S = RED; end
      S5: begin light_M1 = RED; light_M2 = RED; light_MT = RED; light_S = GRN; end
      S6: begin light_M1 = RED; light_M2 = RED; light_MT = RED; light_S = YEL; end
      default: begin
        light_M1 = RED;
        light_M2 = RED;
        light_MT = RED;
        light_S  = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: default-timed and all-ones-timed controllers share one reset;
// expected lamp words are queued per cycle and checked by a separate monitor.
module tb_traffic_light_controller;

  logic       clk;
  logic       rst;
  logic [2:0] a_m1, a_s, a_mt, a_m2;
  logic [2:0] b_m1, b_s, b_mt, b_m2;

  traffic_light_controller u_dflt (
    .clk(clk), .rst(rst),
    .light_M1(a_m1), .light_S(a_s), .light_MT(a_mt), .light_M2(a_m2)
  );

  traffic_light_controller #(.T_MAIN(1), .T_TURN(1), .T_SIDE(1), .T_YEL(1)) u_fast (
    .clk(clk), .rst(rst),
    .light_M1(b_m1), .light_S(b_s), .light_MT(b_mt), .light_M2(b_m2)
  );

  typedef struct {
    int          dut;
    logic [11:0] exp;
    string       tag;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;
  bit    inv_en = 1'b0;

  // Packed as {M1, M2, MT, S}
  localparam logic [11:0] P_S1 = 12'b001_001_100_100;
  localparam logic [11:0] P_S2 = 12'b001_010_100_100;
  localparam logic [11:0] P_S3 = 12'b001_100_001_100;
  localparam logic [11:0] P_S4 = 12'b010_100_010_100;
  localparam logic [11:0] P_S5 = 12'b100_100_100_001;
  localparam logic [11:0] P_S6 = 12'b100_100_100_010;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Default timing 7/2/5/2/3/2: phase after e edges since the start of S1
  function automatic logic [11:0] exp_dflt(input int e);
    int p;
    p = e % 21;
    if (p < 7)       return P_S1;
    else if (p < 9)  return P_S2;
    else if (p < 14) return P_S3;
    else if (p < 16) return P_S4;
    else if (p < 19) return P_S5;
    else             return P_S6;
  endfunction

  function automatic logic [11:0] exp_fast(input int e);
    case (e % 6)
      0: return P_S1;
      1: return P_S2;
      2: return P_S3;
      3: return P_S4;
      4: return P_S5;
      default: return P_S6;
    endcase
  endfunction

  function automatic bit inv_ok(input logic [11:0] w);
    logic [2:0] m1, m2, mt, s;
    {m1, m2, mt, s} = w;
    if ($countones(m1) != 1 || $countones(m2) != 1 ||
        $countones(mt) != 1 || $countones(s) != 1) return 1'b0;
    if (s != 3'b100 && (m1 != 3'b100 || m2 != 3'b100 || mt != 3'b100)) return 1'b0;
    if (mt == 3'b001 && m2 != 3'b100) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int d, input logic [11:0] v, input string tag);
    item_t it;
    it.dut = d;
    it.exp = v;
    it.tag = tag;
    q.push_back(it);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains the expectations queued for this cycle at the falling edge
  always @(negedge clk) begin
    item_t       it;
    logic [11:0] act;
    while (q.size() > 0) begin
      it  = q.pop_front();
      act = (it.dut == 0) ? {a_m1, a_m2, a_mt, a_s} : {b_m1, b_m2, b_mt, b_s};
      total = total + 1;
      if (act !== it.exp) begin
        bad = bad + 1;
        $display("FAIL %s dut%0d actual=%b required=%b", it.tag, it.dut, act, it.exp);
      end
    end
  end

  // Invariant checker: one-hot lamps and conflict-free phases every cycle
  always @(negedge clk) begin
    if (inv_en) begin
      total = total + 2;
      if (!inv_ok({a_m1, a_m2, a_mt, a_s})) begin
        bad = bad + 1;
        $display("FAIL invariant dut0 actual=%b required=one-hot,conflict-free", {a_m1, a_m2, a_mt, a_s});
      end
      if (!inv_ok({b_m1, b_m2, b_mt, b_s})) begin
        bad = bad + 1;
        $display("FAIL invariant dut1 actual=%b required=one-hot,conflict-free", {b_m1, b_m2, b_mt, b_s});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    #2 rst = 1'b1;
    inv_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      push(0, P_S1, "reset_hold");
      push(1, P_S1, "reset_hold");
    end
    rst = 1'b0;

    for (int e = 1; e <= 31; e++) begin
      tick();
      push(0, exp_dflt(e), "cycle");
      push(1, exp_fast(e), "cycle_fast");
    end

    // Edge 32 leaves the default controller in S3 with cnt=2; reset lands between edges
    tick();
    rst = 1'b1;
    push(0, P_S1, "mid_reset");
    push(1, P_S1, "mid_reset_fast");
    for (int i = 0; i < 3; i++) begin
      tick();
      push(0, P_S1, "mid_reset_hold");
      push(1, P_S1, "mid_reset_hold_fast");
    end
    rst = 1'b0;

    for (int e = 1; e <= 100; e++) begin
      tick();
      push(0, exp_dflt(e), "after_reset");
      push(1, exp_fast(e), "after_reset_fast");
    end

    @(negedge clk);
    #1;
    inv_en = 1'b0;
    if (q.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
